pline_credit_buf: RTL and testbench
===================================

// Module: pline_credit_buf
// PURPOSE
//  Credit-based elastic buffer placed directly downstream of a fixed-latency pipeline.
//  Pipeline output is valid-only and has no backpressure. This block supplies backpressure.
//  Upstream may launch an item only while a credit is free. Each launched item is
//  guaranteed a slot in the local FIFO when it emerges P_LAT cycles later, so nothing is dropped.
//  Drains to a standard valid/ready consumer.
// PARAMETERS
//  P_WIDTH  8  data width of in_dat/out_dat
//  P_DEPTH  8  FIFO entries = total credits; any value >=2, need not be power of 2
//  P_LAT    4  upstream pipeline latency; informational + bench check only
//              P_DEPTH >= P_LAT+1 needed for full throughput
// PORTS
//  clk       in   1                  clock
//  rst_n     in   1                  reset, synchronous, active-low
//  issue     in   1                  upstream launches an item into the pipeline this cycle
//  issue_ok  out  1                  credit available; issue is legal this cycle
//  in_vld    in   1                  item emerging from pipeline output
//  in_dat    in   P_WIDTH            data of emerging item
//  out_vld   out  1                  FIFO head valid
//  out_dat   out  P_WIDTH            FIFO head data
//  out_rdy   in   1                  consumer accepts head; pop = out_vld & out_rdy
//  credits   out  clog2(P_DEPTH+1)   free credits
//  count     out  clog2(P_DEPTH+1)   FIFO occupancy
//  err       out  1                  sticky: illegal issue or overflow seen
// BEHAVIOUR
//  Reset (sync, rst_n=0 at posedge):
//   credits=P_DEPTH, count=0, rd/wr ptr=0, err=0, out_vld=0, issue_ok=1.
//   FIFO memory is not cleared. Reset overrides all same-cycle events.
//  Credits:
//   issue_ok = (credits!=0), combinational from the register.
//   Per cycle: credits += pop - (issue & issue_ok).
//   Issue and pop in the same cycle: credits unchanged.
//  Illegal issue (issue & credits==0): no decrement; err<=1. Issue is never blocked combinationally.
//  Push: in_vld writes mem[wr_ptr].
//   Latency: in_vld at edge N gives out_vld=1 and out_dat=in_dat after edge N+1. No bypass.
//  Pop: out_vld = (count!=0); out_dat = mem[rd_ptr] (register read, no extra stage).
//  Push and pop in the same cycle: count unchanged. Both pointers advance.
//   Allowed when full (pop frees the slot the push uses) and when empty (count 0->1; popped entry does not exist).
//  Pointer wrap: ptr==P_DEPTH-1 advances to 0. Explicit compare, no modulo-2^n.
//  Overflow (in_vld & count==P_DEPTH & !pop): item dropped, no pointer/count change, err<=1.
//   Cannot occur if the credit protocol is honoured.
//  Pop while empty: out_rdy ignored; no state change.
//  Invariant: credits + count + in_flight == P_DEPTH.
//   in_flight = items issued but not yet in_vld.
//  Reset mid-operation: reset the upstream pipeline in the same cycle (common rst_n).
//   Otherwise in-flight items arrive with no credit.
//  err clears only on reset.
// STRUCTURE
//  pline_pkg: function clog2; localparam-style CNT_W = clog2(P_DEPTH+1).
//   Shared with the delay-line stage and other pipeline blocks.
//  One sub-module: pline_sfifo.
//   Sync FIFO with wrap pointers, count, full/empty, overflow flag.
//  Top level holds the credit counter, the err register and the FIFO instance. No FSM beyond counters.
// TESTING
//  - Issue every cycle, P_DEPTH=8, P_LAT=4, out_rdy=1.
//    -> issue_ok stays 1; out stream equals in stream; count<=1; err=0.
//  - out_rdy=0, issue until issue_ok=0.
//    -> exactly 8 issues accepted; count reaches 8 after the last arrival; credits=0.
//  - Then out_rdy=1 for 3 cycles.
//    -> 3 pops in order; credits=3; each head appears the cycle after the prior pop.
//  - Full FIFO, in_vld and pop in the same cycle; then wr_ptr wrap 7->0.
//    -> count stays 8; data order preserved across the wrap.
//  - Force issue with credits=0, and in_vld while full with out_rdy=0.
//    -> credits stay 0; item dropped; err=1 and sticky.
//  - Assert rst_n=0 with count=5 and credits=1 (2 in flight).
//    -> next cycle credits=8, count=0, out_vld=0, err=0.
//  - Bench checks the invariant credits+count+in_flight==8 every cycle.

Source files
------------

// File: rtl/pline_pkg.sv
// Shared helpers for the pline_* blocks: constant log2 and counter-width sizing.
package pline_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    // Width of a counter that must hold 0..depth inclusive (credits, occupancy).
    function automatic int cnt_w(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pline_credit_buf_if.sv
// Upstream issue/emerge and downstream valid/ready bundle for pline_credit_buf.
interface pline_credit_buf_if
    import pline_pkg::*;
#(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 8
);
    localparam int CNT_W = cnt_w(P_DEPTH);

    logic               issue;
    logic               issue_ok;
    logic               in_vld;
    logic [P_WIDTH-1:0] in_dat;
    logic               out_vld;
    logic [P_WIDTH-1:0] out_dat;
    logic               out_rdy;
    logic [CNT_W-1:0]   credits;
    logic [CNT_W-1:0]   count;
    logic               err;

    modport master (
        output issue, in_vld, in_dat, out_rdy,
        input  issue_ok, out_vld, out_dat, credits, count, err
    );

    modport slave (
        input  issue, in_vld, in_dat, out_rdy,
        output issue_ok, out_vld, out_dat, credits, count, err
    );
endinterface

// File: rtl/pline_sfifo.sv
// Synchronous FIFO, arbitrary depth >= 2, registered-array read of the head.
// A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
module pline_sfifo
    import pline_pkg::*;
#(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 8,
    localparam int CNT_W  = cnt_w(P_DEPTH),
    localparam int PTR_W  = clog2(P_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [P_WIDTH-1:0] push_dat,
    input  logic               pop,
    output logic [P_WIDTH-1:0] pop_dat,
    output logic               empty,
    output logic [CNT_W-1:0]   count,
    output logic               ovf
);
    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               full, push_en, pop_en;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(P_DEPTH));
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);
    assign ovf     = push & full & ~pop_en;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_dat;
    end

    // Depth need not be a power of two, so wrap on an explicit compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en)
                wr_ptr <= (wr_ptr == PTR_W'(P_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop_en)
                rd_ptr <= (rd_ptr == PTR_W'(P_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pline_credit_buf.sv
// Credit-managed landing buffer for a valid-only fixed-latency pipeline.
// Every credit granted upstream reserves one FIFO slot for the item P_LAT cycles later.
module pline_credit_buf
    import pline_pkg::*;
#(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 8,
    parameter int P_LAT   = 4
) (
    input  logic clk,
    input  logic rst_n,
    pline_credit_buf_if.slave bus
);
    localparam int CNT_W = cnt_w(P_DEPTH);

    if (P_DEPTH < 2) begin : g_bad_depth
        $error("pline_credit_buf: P_DEPTH must be at least 2");
    end
    if (P_DEPTH < P_LAT + 1) begin : g_rate_note
        $warning("pline_credit_buf: P_DEPTH < P_LAT+1 limits issue rate");
    end

    logic [CNT_W-1:0]   credits;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [P_WIDTH-1:0] head_dat;
    logic               fifo_empty, fifo_ovf;
    logic               issue_ok, issue_acc, issue_bad, out_vld, pop, err;

    assign issue_ok  = (credits != '0);
    assign issue_acc = bus.issue & issue_ok;
    // An issue without credit is only flagged; the pipeline cannot be stalled.
    assign issue_bad = bus.issue & ~issue_ok;
    assign out_vld   = ~fifo_empty;
    assign pop       = out_vld & bus.out_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits <= CNT_W'(P_DEPTH);
        end else begin
            case ({pop, issue_acc})
                2'b10:   credits <= credits + CNT_W'(1);
                2'b01:   credits <= credits - CNT_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                     err <= 1'b0;
        else if (issue_bad | fifo_ovf)  err <= 1'b1;
    end

    pline_sfifo #(
        .P_WIDTH (P_WIDTH),
        .P_DEPTH (P_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (bus.in_vld),
        .push_dat (bus.in_dat),
        .pop      (pop),
        .pop_dat  (head_dat),
        .empty    (fifo_empty),
        .count    (fifo_cnt),
        .ovf      (fifo_ovf)
    );

    assign bus.issue_ok = issue_ok;
    assign bus.out_vld  = out_vld;
    assign bus.out_dat  = head_dat;
    assign bus.credits  = credits;
    assign bus.count    = fifo_cnt;
    assign bus.err      = err;
endmodule

// File: tb/tb_pline_credit_buf.sv
// Bench for pline_credit_buf: directed table, corner sequences and random traffic
// against a queue-based model that also plays the role of the upstream pipeline.
module tb_pline_credit_buf;
    import pline_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int LAT   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pline_credit_buf_if #(.P_WIDTH(W), .P_DEPTH(DEPTH)) bus ();

    pline_credit_buf #(.P_WIDTH(W), .P_DEPTH(DEPTH), .P_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nvec = 0;
    int nbad = 0;

    // Model state: FIFO contents, free credits, sticky error, pipeline contents.
    logic [W-1:0] q[$];
    int           mcred = DEPTH;
    bit           merr  = 1'b0;
    bit           pv [LAT];
    logic [W-1:0] pd [LAT];
    bit           manual = 1'b1;
    bit           inv_on = 1'b0;
    int           nlegal = 0;

    typedef struct {
        bit       iss;
        bit       vld;
        logic [W-1:0] dat;
        bit       rdy;
        int       e_cred;
        int       e_cnt;
        bit       e_vld;
        logic [W-1:0] e_dat;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    // In auto mode in_vld/in_dat come from the model pipeline fed by legal issues.
    task automatic step(input bit iss, input bit mvld, input logic [W-1:0] mdat,
                        input bit rdy, input bit rst);
        bit           v, pop, legal;
        logic [W-1:0] d;
        int           inflight;
        @(negedge clk);
        if (manual) begin v = mvld; d = mdat; end
        else        begin v = pv[LAT-1]; d = pd[LAT-1]; end
        bus.issue   = iss;
        bus.in_vld  = v;
        bus.in_dat  = d;
        bus.out_rdy = rdy;
        rst_n       = ~rst;
        if (rst) begin
            q.delete();
            mcred = DEPTH;
            merr  = 1'b0;
            for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
        end else begin
            pop   = rdy && (q.size() != 0);
            legal = iss && (mcred != 0);
            if (iss && !legal) merr = 1'b1;
            mcred = mcred + int'(pop) - int'(legal);
            if (pop) void'(q.pop_front());
            if (v) begin
                if (q.size() < DEPTH) q.push_back(d);
                else                  merr = 1'b1;
            end
            if (legal) nlegal++;
            if (!manual) begin
                for (int i = LAT - 1; i > 0; i--) begin
                    pv[i] = pv[i-1];
                    pd[i] = pd[i-1];
                end
                pv[0] = legal;
                pd[0] = W'($urandom);
            end
        end
        @(posedge clk);
        #1;
        chk("credits", int'(bus.credits), mcred);
        chk("count", int'(bus.count), q.size());
        chk("out_vld", int'(bus.out_vld), int'(q.size() != 0));
        chk("issue_ok", int'(bus.issue_ok), int'(mcred != 0));
        chk("err", int'(bus.err), int'(merr));
        if (q.size() != 0) chk("out_dat", int'(bus.out_dat), int'(q[0]));
        if (inv_on) begin
            inflight = 0;
            for (int i = 0; i < LAT; i++) inflight += int'(pv[i]);
            chk("invariant", int'(bus.credits) + int'(bus.count) + inflight, DEPTH);
        end
    endtask

    task automatic do_reset();
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
    endtask

    task automatic fill_until_no_credit(output int n);
        n = 0;
        for (int g = 0; g < 30 && mcred != 0; g++) begin
            step(1, 0, '0, 0, 0);
            n++;
        end
    endtask

    initial begin
        int n;
        bus.issue = 1'b0; bus.in_vld = 1'b0; bus.in_dat = '0; bus.out_rdy = 1'b0;

        // iss vld dat rdy | credits count out_vld out_dat
        tbl[0] = '{1, 0, 8'h00, 0, 7, 0, 0, 8'h00};
        tbl[1] = '{1, 0, 8'h00, 0, 6, 0, 0, 8'h00};
        tbl[2] = '{0, 1, 8'hA1, 0, 6, 1, 1, 8'hA1};
        tbl[3] = '{0, 1, 8'hA2, 1, 7, 1, 1, 8'hA2};
        tbl[4] = '{0, 0, 8'h00, 1, 8, 0, 0, 8'h00};
        tbl[5] = '{0, 0, 8'h00, 1, 8, 0, 0, 8'h00};
        tbl[6] = '{1, 0, 8'h00, 0, 7, 0, 0, 8'h00};
        tbl[7] = '{0, 1, 8'hB1, 1, 7, 1, 1, 8'hB1};
        tbl[8] = '{1, 0, 8'h00, 1, 7, 0, 0, 8'h00};

        manual = 1'b1; inv_on = 1'b0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].iss, tbl[i].vld, tbl[i].dat, tbl[i].rdy, 0);
            chk($sformatf("tbl%0d_credits", i), int'(bus.credits), tbl[i].e_cred);
            chk($sformatf("tbl%0d_count", i), int'(bus.count), tbl[i].e_cnt);
            chk($sformatf("tbl%0d_out_vld", i), int'(bus.out_vld), int'(tbl[i].e_vld));
            if (tbl[i].e_vld)
                chk($sformatf("tbl%0d_out_dat", i), int'(bus.out_dat), int'(tbl[i].e_dat));
        end

        // Issue every cycle with a ready consumer.
        manual = 1'b0;
        do_reset();
        inv_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, '0, 1, 0);
            chk("stream_issue_ok", int'(bus.issue_ok), 1);
            chk("stream_count_le1", int'(bus.count <= 1), 1);
        end
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 0);

        // Blocked consumer: exactly DEPTH issues granted, then the FIFO fills.
        fill_until_no_credit(n);
        chk("issues_accepted", n, DEPTH);
        for (int i = 0; i < LAT + 1; i++) step(0, 0, '0, 0, 0);
        chk("full_count", int'(bus.count), DEPTH);
        chk("full_credits", int'(bus.credits), 0);

        // Three pops in order.
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0);
        chk("after3_credits", int'(bus.credits), 3);
        chk("after3_count", int'(bus.count), 5);

        // Refill, then push+pop while full across the pointer wrap.
        fill_until_no_credit(n);
        chk("refill_issues", n, 3);
        for (int i = 0; i < LAT + 1; i++) step(0, 0, '0, 0, 0);
        manual = 1'b1; inv_on = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, W'(8'hC0 + i), 1, 0);
            chk("full_pushpop_count", int'(bus.count), DEPTH);
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, '0, 1, 0);

        // Illegal issue and overflow set a sticky err.
        manual = 1'b0;
        do_reset();
        inv_on = 1'b1;
        fill_until_no_credit(n);
        for (int i = 0; i < LAT + 1; i++) step(0, 0, '0, 0, 0);
        manual = 1'b1; inv_on = 1'b0;
        step(1, 0, '0, 0, 0);
        chk("illegal_credits", int'(bus.credits), 0);
        chk("illegal_err", int'(bus.err), 1);
        step(0, 1, 8'h5A, 0, 0);
        chk("ovf_count", int'(bus.count), DEPTH);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 0);
        chk("err_sticky", int'(bus.err), 1);

        // Reset with 5 buffered and 2 in flight.
        manual = 1'b0;
        do_reset();
        inv_on = 1'b1;
        for (int i = 0; i < 7; i++) step(1, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);
        chk("pre_rst_count", int'(bus.count), 5);
        chk("pre_rst_credits", int'(bus.credits), 1);
        step(0, 0, '0, 1, 1);
        chk("rst_credits", int'(bus.credits), DEPTH);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_out_vld", int'(bus.out_vld), 0);
        chk("rst_err", int'(bus.err), 0);

        // Random legal traffic.
        for (int i = 0; i < 1500; i++)
            step((mcred != 0) && ($urandom_range(0, 3) != 0), 0, '0,
                 bit'($urandom_range(0, 1)), 0);
        for (int i = 0; i < LAT + DEPTH + 2; i++) step(0, 0, '0, 1, 0);
        chk("final_credits", int'(bus.credits), DEPTH);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
